muldiv_engine: RTL and testbench

Multi-cycle multiply/divide responder for the EX stage. It accepts `multicyc_req_t` requests from the execute stage and returns `multicyc_resp_t`. The response carries a `ready` stall signal and the new 64-bit HI/LO value, which the EX stage writes into its hilo register. The block serves MULT/MULTU/MADD/MADDU/MSUB/MSUBU with a fixed-latency multiplier and DIV/DIVU with a radix-2 restoring divider; MTHI/MTLO resolve combinationally.

---
 rtl/muldiv_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_muldiv_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_engine.sv
// muldiv_engine: multi-cycle HI/LO unit for the EX stage.
// Fixed-latency multiplier and radix-2 restoring divider; MTHI/MTLO resolve combinationally.
package muldiv_pkg;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_MULT,
      OP_MULTU,
      OP_MADD,
      OP_MADDU,
      OP_MSUB,
      OP_MSUBU,
      OP_DIV,
      OP_DIVU,
      OP_MTHI,
      OP_MTLO,
      OP_MFHI,
      OP_MFLO
   } oper_t;

   typedef struct packed {
      oper_t       op;
      logic [31:0] reg0;
      logic [31:0] reg1;
      logic        is_multicyc;
      logic [63:0] hilo;
   } multicyc_req_t;

   typedef struct packed {
      logic        ready;
      logic [63:0] hilo;
   } multicyc_resp_t;

endpackage

module muldiv_engine
   import muldiv_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  multicyc_req_t  multicyc_req,
   input  logic           flush,
   input  logic           accept,
   output multicyc_resp_t multicyc_resp
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   oper_t       op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] rem_q, rem_d;
   logic [63:0] h_q, h_d;
   logic [63:0] res_q, res_d;
   logic        quo_neg_q, quo_neg_d;
   logic        rem_neg_q, rem_neg_d;

   logic        req_mul;
   logic        req_div;
   logic        div_signed;
   logic        start;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [63:0] mul_res;
   logic [32:0] div_trial;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   always_comb begin
      req_mul = 1'b0;
      req_div = 1'b0;
      case (multicyc_req.op)
         OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: req_mul = 1'b1;
         OP_DIV, OP_DIVU: req_div = 1'b1;
         default: ;
      endcase
      div_signed = (multicyc_req.op == OP_DIV);
      start      = (state_q == S_IDLE) && multicyc_req.is_multicyc && !flush
                   && (req_mul || req_div);
   end

   // Operands are extended to 64 bits so one multiplier serves signed and unsigned ops.
   always_comb begin
      if (op_q == OP_MULT || op_q == OP_MADD || op_q == OP_MSUB) begin
         ext_a = {{32{a_q[31]}}, a_q};
         ext_b = {{32{b_q[31]}}, b_q};
      end else begin
         ext_a = {32'd0, a_q};
         ext_b = {32'd0, b_q};
      end
      prod = ext_a * ext_b;
      case (op_q)
         OP_MADD, OP_MADDU: mul_res = h_q + prod;
         OP_MSUB, OP_MSUBU: mul_res = h_q - prod;
         default:           mul_res = prod;
      endcase
   end

   // a_q holds the dividend while it shifts out and the quotient while it shifts in.
   // When the trial fits, the true difference is below 2^32, so a 32-bit subtract suffices.
   always_comb begin
      div_trial = {rem_q, a_q[31]};
      div_ge    = (div_trial >= {1'b0, b_q});
      div_diff  = div_trial[31:0] - b_q;
      quo_fix   = quo_neg_q ? (~a_q + 32'd1) : a_q;
      rem_fix   = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      h_d       = h_q;
      res_d     = res_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;

      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_d  = multicyc_req.op;
                  rem_d = '0;
                  if (req_mul) begin
                     a_d     = multicyc_req.reg0;
                     b_d     = multicyc_req.reg1;
                     h_d     = multicyc_req.hilo;
                     cnt_d   = 5'(MUL_LATENCY - 1);
                     state_d = S_MUL;
                  end else if (multicyc_req.reg1 == '0) begin
                     res_d   = {multicyc_req.reg0, 32'hFFFF_FFFF};
                     state_d = S_DONE;
                  end else begin
                     a_d       = (div_signed && multicyc_req.reg0[31]) ?
                                 (~multicyc_req.reg0 + 32'd1) : multicyc_req.reg0;
                     b_d       = (div_signed && multicyc_req.reg1[31]) ?
                                 (~multicyc_req.reg1 + 32'd1) : multicyc_req.reg1;
                     quo_neg_d = div_signed && (multicyc_req.reg0[31] ^ multicyc_req.reg1[31]);
                     rem_neg_d = div_signed && multicyc_req.reg0[31];
                     cnt_d     = 5'd31;
                     state_d   = S_DIV;
                  end
               end
            end
            S_MUL: begin
               if (cnt_q == '0) begin
                  res_d   = mul_res;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            S_DIV: begin
               if (div_ge) begin
                  rem_d = div_diff;
                  a_d   = {a_q[30:0], 1'b1};
               end else begin
                  rem_d = div_trial[31:0];
                  a_d   = {a_q[30:0], 1'b0};
               end
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            S_FIX: begin
               res_d   = {rem_fix, quo_fix};
               state_d = S_DONE;
            end
            S_DONE: begin
               if (accept) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      multicyc_resp.ready = 1'b1;
      multicyc_resp.hilo  = multicyc_req.hilo;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               multicyc_resp.ready = 1'b0;
            end else if (multicyc_req.op == OP_MTHI) begin
               multicyc_resp.hilo = {multicyc_req.reg0, multicyc_req.hilo[31:0]};
            end else if (multicyc_req.op == OP_MTLO) begin
               multicyc_resp.hilo = {multicyc_req.hilo[63:32], multicyc_req.reg0};
            end
         end
         S_DONE: begin
            multicyc_resp.hilo = res_q;
         end
         default: begin
            multicyc_resp.ready = 1'b0;
            multicyc_resp.hilo  = res_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= OP_NOP;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         h_q       <= '0;
         res_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         h_q       <= h_d;
         res_q     <= res_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
      end
   end

endmodule

// File: tb/tb_muldiv_engine.sv
// Directed self-checking bench for muldiv_engine with hand-computed HI/LO results.
module tb_muldiv_engine;
   import muldiv_pkg::*;

   logic           clk;
   logic           rst_n;
   logic           flush;
   logic           accept;
   multicyc_req_t  req;
   multicyc_resp_t resp;

   int unsigned n_checks;
   int unsigned n_pass;

   localparam logic [63:0] IDLE_HILO = 64'h1111_2222_3333_4444;

   muldiv_engine #(.MUL_LATENCY(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .multicyc_req  (req),
      .flush         (flush),
      .accept        (accept),
      .multicyc_resp (resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input oper_t op, input logic [31:0] r0, input logic [31:0] r1,
                        input logic [63:0] h);
      req.op          = op;
      req.reg0        = r0;
      req.reg1        = r1;
      req.hilo        = h;
      req.is_multicyc = 1'b1;
   endtask

   // Counts cycles from issue until ready, bounded, then checks latency and result.
   task automatic wait_done(input string tag, input int lat, input logic [63:0] exp);
      int cycles;
      cycles = 0;
      #1;
      while (!resp.ready && cycles < 100) begin
         @(posedge clk);
         #2;
         cycles++;
      end
      check({tag, "_lat"}, 64'(cycles), 64'(lat));
      check({tag, "_hilo"}, resp.hilo, exp);
   endtask

   task automatic retire(input string tag);
      accept          = 1'b1;
      req.is_multicyc = 1'b0;
      req.op          = OP_NOP;
      req.hilo        = IDLE_HILO;
      @(posedge clk);
      #1;
      accept = 1'b0;
      #1;
      check({tag, "_idle_rdy"}, 64'(resp.ready), 64'd1);
      check({tag, "_idle_hilo"}, resp.hilo, IDLE_HILO);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      accept   = 1'b0;
      req      = '0;
      req.hilo = IDLE_HILO;
      #2;
      check("rst_rdy", 64'(resp.ready), 64'd1);
      check("rst_hilo", resp.hilo, IDLE_HILO);
      req.op          = OP_MULT;
      req.is_multicyc = 1'b1;
      #1;
      check("rst_start_rdy", 64'(resp.ready), 64'd0);
      req.is_multicyc = 1'b0;
      check("rst_nostart_hilo", resp.hilo, IDLE_HILO);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Combinational moves
      req.op          = OP_MTHI;
      req.reg0        = 32'h1234_5678;
      req.hilo        = 64'hAAAA_AAAA_BBBB_BBBB;
      req.is_multicyc = 1'b1;
      #1;
      check("mthi_rdy", 64'(resp.ready), 64'd1);
      check("mthi_hilo", resp.hilo, 64'h1234_5678_BBBB_BBBB);
      req.op = OP_MTLO;
      #1;
      check("mtlo_hilo", resp.hilo, 64'hAAAA_AAAA_1234_5678);
      req.op          = OP_DIV;
      req.is_multicyc = 1'b0;
      #1;
      check("div_nomc_rdy", 64'(resp.ready), 64'd1);
      check("div_nomc_hilo", resp.hilo, 64'hAAAA_AAAA_BBBB_BBBB);

      @(posedge clk);
      #1;
      issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'd0);
      wait_done("mult", 4, 64'hFFFF_FFFF_FFFF_FFFA);
      retire("mult");

      issue(OP_MADDU, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done("maddu", 4, 64'h0);
      retire("maddu");

      issue(OP_MSUB, 32'd2, 32'd3, 64'h0);
      wait_done("msub", 4, 64'hFFFF_FFFF_FFFF_FFFA);
      retire("msub");

      issue(OP_MADD, 32'hFFFF_FFFE, 32'd3, 64'd10);
      wait_done("madd", 4, 64'd4);
      retire("madd");

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'h0);
      wait_done("div_neg", 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      retire("div_neg");

      issue(OP_DIVU, 32'd100, 32'd7, 64'h0);
      wait_done("divu", 34, {32'd2, 32'd14});
      retire("divu");

      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0);
      wait_done("div_ovf", 34, {32'd0, 32'h8000_0000});
      retire("div_ovf");

      issue(OP_DIVU, 32'd5, 32'd0, 64'h0);
      wait_done("div0", 1, {32'd5, 32'hFFFF_FFFF});
      retire("div0");

      // Flush ten cycles into a divide
      issue(OP_DIV, 32'd1000, 32'd3, 64'h0);
      repeat (10) @(posedge clk);
      #1;
      flush           = 1'b1;
      req.is_multicyc = 1'b0;
      #1;
      check("flush_busy_rdy", 64'(resp.ready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      check("flush_idle_rdy", 64'(resp.ready), 64'd1);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0);
      wait_done("multu", 4, {32'd1, 32'hFFFF_FFFE});
      retire("multu");

      // DONE holds with accept low; request kept presented must not restart
      issue(OP_MULT, 32'd5, 32'd7, 64'h0);
      wait_done("hold", 4, 64'd35);
      req.reg0 = 32'd9;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         check("hold_rdy", 64'(resp.ready), 64'd1);
         check("hold_hilo", resp.hilo, 64'd35);
      end
      retire("hold");

      // Asynchronous reset in the middle of a multiply
      issue(OP_MULT, 32'd5, 32'd7, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      req.is_multicyc = 1'b0;
      req.op          = OP_NOP;
      req.hilo        = IDLE_HILO;
      #1;
      check("mulrst_busy_rdy", 64'(resp.ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("mulrst_rdy", 64'(resp.ready), 64'd1);
      check("mulrst_hilo", resp.hilo, IDLE_HILO);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(OP_MULTU, 32'd6, 32'd7, 64'h0);
      wait_done("post_rst", 4, 64'd42);
      retire("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
